// File: rtl/lfsr_gen_if.sv
// Output word handshake between lfsr_gen and its consumer.
// The master drives valid/data and the slave answers with ready.
interface lfsr_gen_if #(
    parameter int OUTW = 8
);
    logic            valid;
    logic            ready;
    logic [OUTW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR whose serial output is packed into OUTW-bit words.
// Words are offered over a valid/ready handshake; zero seeds are replaced by DEFSEED.
//
// state | meaning
// FILL  | shifting on enable, packing bits into the next word
// FULL  | word complete, LFSR frozen until the consumer takes it
module lfsr_gen #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(32'h80200003),
    parameter bit               MODE    = 1'b0,
    parameter int               OUTW    = 8,
    parameter logic [WIDTH-1:0] DEFSEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             enable,
    lfsr_gen_if.master       out_if,
    output logic [WIDTH-1:0] state,
    output logic             lockup
);
    localparam int CW = $clog2(OUTW + 1);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUTW-1:0]  word_q, word_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] lfsr_next;
    logic [OUTW:0]    word_ext;
    logic             shift_ok;
    logic             last_bit;

    always_comb begin
        if (MODE == 1'b0)
            lfsr_next = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};
        else
            lfsr_next = {1'b0, lfsr_q[WIDTH-1:1]} ^ ({WIDTH{lfsr_q[0]}} & TAPS);
    end

    // New bit enters at the top so the first bit of a word ends up in data[0].
    assign word_ext = {lfsr_q[0], word_q};
    assign shift_ok = enable && ((fsm_q == FILL) || out_if.ready);
    assign last_bit = (cnt_q == CW'(OUTW - 1));

    always_comb begin
        fsm_d    = fsm_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        lockup_d = 1'b0;
        if (load) begin
            fsm_d    = FILL;
            cnt_d    = '0;
            lockup_d = (seed == '0);
            lfsr_d   = (seed == '0) ? DEFSEED : seed;
        end else begin
            if (fsm_q == FULL && out_if.ready)
                fsm_d = FILL;
            if (shift_ok) begin
                lfsr_d = lfsr_next;
                word_d = word_ext[OUTW:1];
                if (last_bit) begin
                    cnt_d = '0;
                    fsm_d = FULL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= FILL;
            lfsr_q   <= DEFSEED;
            cnt_q    <= '0;
            word_q   <= '0;
            lockup_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_if.valid = (fsm_q == FULL);
    assign out_if.data  = word_q;
    assign state        = lfsr_q;
    assign lockup       = lockup_q;
endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random word generator: a WIDTH-bit linear-feedback shift register with selectable Fibonacci or Galois feedback and programmable taps. The register's serial output is packed into OUTW-bit words, which are delivered over a valid/ready handshake. It serves as the general-purpose stimulus and scrambler source for test logic and replaces fixed-width, fixed-tap LFSRs. Seed loading is guarded against the all-zero lock-up state.

## Interface
- WIDTH, 32: LFSR state width; must be ≥ 2.
- TAPS, 32'h80200003: feedback tap mask, WIDTH bits, nonzero.
- MODE, 0: 0 = Fibonacci, 1 = Galois.
- OUTW, 8: bits per output word; range 1..64.
- DEFSEED, 1: reset and lock-up replacement seed, WIDTH bits, nonzero.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- seed  in  WIDTH  value loaded when load is high.
- load  in  1  loads seed and restarts word assembly; priority over enable.
- enable  in  1  permits one LFSR shift per cycle.
- ready  in  1  consumer accepts data when valid is high.
- valid  out  1  data holds a complete word.
- data  out  OUTW  assembled word.
- state  out  WIDTH  current LFSR register.
- lockup  out  1  one-cycle pulse: a zero seed was replaced with DEFSEED.

## Operation
- Output bit of a shift: b = state[0].
- Fibonacci next state: {^(state & TAPS), state[WIDTH-1:1]}.
- Galois next state: {1'b0, state[WIDTH-1:1]} ^ ({WIDTH{state[0]}} & TAPS).
- Word packing: each shift sets word = {b, word[OUTW-1:1]}, so the first bit of a word lands in data[0].
- Bit counter cnt is clog2(OUTW+1) bits wide.
- FSM has two states, FILL and FULL.
- FILL, enable=1: shift, pack b, increment cnt; on the OUTW-th bit go to FULL and set valid=1, cnt=0.
- FILL, enable=0: hold everything.
- FULL: the LFSR is frozen and data is stable while ready=0; enable is ignored.
- FULL with ready=1 is a handshake; the next cycle is FILL with valid=0.
  - If enable=1 in the handshake cycle, one shift happens and counts as bit 1 of the next word (cnt=1).
  - If OUTW=1, that shift completes the next word, so valid stays 1.
- load=1 in any state:
  - state ← seed, or DEFSEED with lockup=1 if seed==0.
  - cnt=0, FSM → FILL, valid=0, no shift that cycle.
  - A pending unaccepted word is discarded.
- lockup is high only in the cycle after a zero-seed load.
- data contents while valid=0 are don't-care.

## Timing
- Reset (synchronous, dominates load): state=DEFSEED, FSM=FILL, cnt=0, valid=0, data=0, lockup=0.
- Latency: valid rises at the edge of the OUTW-th enabled FILL cycle after reset or load.
- Throughput: with enable=ready=1 held, valid is high for 1 cycle in every OUTW; back-to-back with no gap when OUTW=1.
- state updates on the same edge as the shift; it has no extra pipeline stage.
- Simultaneous load and handshake: the current word is accepted (valid was high that cycle) and the load takes effect; the next cycle shows valid=0.
- Simultaneous load and enable: load wins and no shift occurs.

## Test plan
- Reset: WIDTH=4, DEFSEED=4'b0001; assert reset 2 cycles -> state=0001, valid=0, data=0, lockup=0; load during reset is ignored.
- Fibonacci period: WIDTH=4, TAPS=4'b0011, MODE=0, enable=1 from 0001 -> state sequence 1000,0100,0010,1001,1100,0110,1011,0101,1010,1101,1110,1111,0111,0011,0001 (period 15).
- Galois period: TAPS=4'b1100, MODE=1 from 0001 -> 1100,0110,0011,1101,1010,0101,1110,0111,1111,1011,1001,1000,0100,0010,0001.
- Packing and backpressure: Fibonacci case above, OUTW=4, ready=0 -> valid at cycle 4, data=4'b0001, state frozen at 1001 while ready=0. Then pulse ready with enable=1 -> next word data=4'b1001 valid 4 cycles later. With ready=1 held, valid recurs every 4 cycles.
- Lock-up: load=1, seed=0 -> state=DEFSEED, lockup high exactly one cycle, valid=0.
- Mid-fill load: after 2 shifts, load seed=4'b1011 -> cnt restarts; first word after load uses bits from 1011 (state[0] sequence 1,1,0,1 -> data=4'b1011).
